ultrasonic_distance_filter: RTL

//  Downstream consumer of the ultra_sonic echo timer. Accepts each measured echo width (clk cycles),

---
 rtl/ultrasonic_pkg.sv | 30 +++
 rtl/ultrasonic_divider.sv | 70 +++++++
 rtl/ultrasonic_distance_filter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ultrasonic_pkg.sv
// Shared types and constants for the ultrasonic distance filter.
package ultrasonic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    ACCUM  = 2'd2
  } state_t;

  localparam logic [1:0] REG_AVG    = 2'd0;
  localparam logic [1:0] REG_LAST   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_THRESH = 2'd3;

  localparam int unsigned DEF_CYCLES_PER_CM = 2900;
  localparam int unsigned DEF_MAX_COUNT     = 1_160_000;
  localparam int unsigned DEF_LOG2_DEPTH    = 2;
  localparam int unsigned DEF_HYST_CM       = 2;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CM_W   = 16;

  localparam logic [CM_W-1:0] THRESH_RESET = 16'd30;

  // Clamp a full-width quotient into the 16-bit centimetre range.
  function automatic logic [CM_W-1:0] sat_cm(input logic [DATA_W-1:0] q);
    return (|q[DATA_W-1:CM_W]) ? {CM_W{1'b1}} : q[CM_W-1:0];
  endfunction

endpackage

// File: rtl/ultrasonic_divider.sv
// Start/done restoring divider: 32-bit dividend by a constant divisor, one quotient bit per cycle.
module ultrasonic_divider
  import ultrasonic_pkg::*;
#(
  parameter int unsigned DIVISOR = DEF_CYCLES_PER_CM
) (
  input  logic              clk,
  input  logic              reset_all,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  output logic              done,
  output logic [DATA_W-1:0] quotient
);

  localparam int unsigned   STEP_W = 5;
  localparam logic [DATA_W-1:0] DIV_V = DATA_W'(DIVISOR);

  logic              busy_q;
  logic [STEP_W-1:0] step_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;

  logic [DATA_W-1:0] rem_in;
  logic [DATA_W-1:0] quo_in;
  logic [DATA_W-1:0] rem_shift;
  logic [DATA_W-1:0] rem_next;
  logic [DATA_W-1:0] quo_next;

  // The first step runs on the start edge, so 32 bits finish 31 edges later.
  always_comb begin
    rem_in    = start ? '0 : rem_q;
    quo_in    = start ? dividend : quo_q;
    rem_shift = {rem_in[DATA_W-2:0], quo_in[DATA_W-1]};
    rem_next  = rem_shift;
    quo_next  = {quo_in[DATA_W-2:0], 1'b0};
    if (rem_shift >= DIV_V) begin
      rem_next = rem_shift - DIV_V;
      quo_next = {quo_in[DATA_W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset_all) begin
      busy_q <= 1'b0;
      step_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q  <= rem_next;
        quo_q  <= quo_next;
        step_q <= STEP_W'(1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q  <= rem_next;
        quo_q  <= quo_next;
        step_q <= step_q + STEP_W'(1);
        if (step_q == {STEP_W{1'b1}}) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/ultrasonic_distance_filter.sv
// Echo width to centimetres, moving average over 2^LOG2_DEPTH samples, hysteretic
// proximity flag and a small Avalon-MM register window.
module ultrasonic_distance_filter
  import ultrasonic_pkg::*;
#(
  parameter int unsigned CYCLES_PER_CM = DEF_CYCLES_PER_CM,
  parameter int unsigned MAX_COUNT     = DEF_MAX_COUNT,
  parameter int unsigned LOG2_DEPTH    = DEF_LOG2_DEPTH,
  parameter int unsigned HYST_CM       = DEF_HYST_CM
) (
  input  logic              clk,
  input  logic              reset_all,
  input  logic              count_valid,
  input  logic [DATA_W-1:0] count,
  input  logic [1:0]        addr,
  input  logic              read_en,
  input  logic              write_en,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              avg_valid,
  output logic              near
);

  localparam int unsigned DEPTH  = 1 << LOG2_DEPTH;
  localparam int unsigned PTR_W  = LOG2_DEPTH;
  localparam int unsigned FILL_W = LOG2_DEPTH + 1;
  localparam int unsigned SUM_W  = CM_W + LOG2_DEPTH;

  state_t state_q;
  state_t state_next;

  logic accept_c;
  logic reject_c;
  logic busy_strobe_c;
  logic accum_en_c;
  logic in_range_c;

  logic              div_done;
  logic [DATA_W-1:0] div_quotient;
  logic [CM_W-1:0]   q_cm;

  logic [CM_W-1:0]   sample_buf [DEPTH];
  logic [SUM_W-1:0]  sum_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [FILL_W-1:0] fill_q;
  logic [CM_W-1:0]   avg_cm_q;
  logic [CM_W-1:0]   last_cm_q;
  logic [CM_W-1:0]   threshold_q;
  logic              accum_done_q;
  logic              overrun_q;
  logic              out_of_range_q;

  logic [CM_W-1:0] avg_next;
  logic            status_wr;
  logic            thresh_wr;
  logic            unused_wdata;

  assign in_range_c = (count != '0) && (count <= DATA_W'(MAX_COUNT));
  assign q_cm       = sat_cm(div_quotient);
  assign avg_next   = CM_W'(sum_q >> LOG2_DEPTH);
  assign status_wr  = write_en && (addr == REG_STATUS);
  assign thresh_wr  = write_en && (addr == REG_THRESH);
  assign unused_wdata = ^write_data[DATA_W-1:CM_W];

  ultrasonic_divider #(
    .DIVISOR (CYCLES_PER_CM)
  ) u_divider (
    .clk      (clk),
    .reset_all(reset_all),
    .start    (accept_c),
    .dividend (count),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge clk) begin
    if (reset_all) state_q <= IDLE;
    else           state_q <= state_next;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_next    = state_q;
    accept_c      = 1'b0;
    reject_c      = 1'b0;
    busy_strobe_c = 1'b0;
    accum_en_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_valid) begin
          if (in_range_c) begin
            accept_c   = 1'b1;
            state_next = DIVIDE;
          end else begin
            reject_c = 1'b1;
          end
        end
      end
      DIVIDE: begin
        busy_strobe_c = count_valid;
        if (div_done) state_next = ACCUM;
      end
      ACCUM: begin
        busy_strobe_c = count_valid;
        accum_en_c    = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Window update, then the averaged result one cycle later.
  always_ff @(posedge clk) begin
    if (reset_all) begin
      for (int i = 0; i < int'(DEPTH); i++) sample_buf[i] <= '0;
      sum_q        <= '0;
      ptr_q        <= '0;
      fill_q       <= '0;
      last_cm_q    <= '0;
      avg_cm_q     <= '0;
      accum_done_q <= 1'b0;
      avg_valid    <= 1'b0;
      near         <= 1'b0;
    end else begin
      accum_done_q <= accum_en_c;
      avg_valid    <= 1'b0;
      if (accum_en_c) begin
        sum_q             <= sum_q - SUM_W'(sample_buf[ptr_q]) + SUM_W'(q_cm);
        sample_buf[ptr_q] <= q_cm;
        ptr_q             <= ptr_q + PTR_W'(1);
        last_cm_q         <= q_cm;
        if (fill_q != FILL_W'(DEPTH)) fill_q <= fill_q + FILL_W'(1);
      end
      if (accum_done_q && (fill_q == FILL_W'(DEPTH))) begin
        avg_cm_q  <= avg_next;
        avg_valid <= 1'b1;
        if (avg_next < threshold_q) begin
          near <= 1'b1;
        end else if ({1'b0, avg_next} >= ({1'b0, threshold_q} + (CM_W+1)'(HYST_CM))) begin
          near <= 1'b0;
        end
      end
    end
  end

  // Sticky flags: a set in the same cycle as a status write wins.
  always_ff @(posedge clk) begin
    if (reset_all) begin
      overrun_q      <= 1'b0;
      out_of_range_q <= 1'b0;
      threshold_q    <= THRESH_RESET;
    end else begin
      if (busy_strobe_c)  overrun_q <= 1'b1;
      else if (status_wr) overrun_q <= 1'b0;
      if (reject_c)       out_of_range_q <= 1'b1;
      else if (status_wr) out_of_range_q <= 1'b0;
      if (thresh_wr)      threshold_q <= write_data[CM_W-1:0];
    end
  end

  always_comb begin
    read_data = '0;
    if (read_en) begin
      unique case (addr)
        REG_AVG:    read_data = {16'd0, avg_cm_q};
        REG_LAST:   read_data = {16'd0, last_cm_q};
        REG_STATUS: read_data = {16'd0, 8'(fill_q), 5'd0, out_of_range_q, overrun_q, near};
        REG_THRESH: read_data = {16'd0, threshold_q};
        default:    read_data = '0;
      endcase
    end
  end

endmodule
